// File: rtl/modulo_mux4_1_scan_if.sv
// rtl/modulo_mux4_1_scan_if.sv - bus interface for the 4:1 round-robin scanner
//
// Purpose: bundles the scanner's data/control inputs and scan outputs.
//   Optional macro: MUX_SCAN_PARITY_EN adds parity output P.
// Signals:
//   E      scan enable (0 pauses)
//   MASK   per-channel enable, bit k scans channel k
//   D0..D3 channel data words, W bits
//   S      select for modulo_demux1_4, S[1]=ch[0], S[0]=ch[1]
//   CH     current channel index
//   Y      last captured data word
//   YCH    channel index Y came from
//   V      one-cycle strobe marking a fresh Y
//   P      even parity of Y (MUX_SCAN_PARITY_EN only)
// Modports: master drives inputs (source side), slave is the scanner.

interface modulo_mux4_1_scan_if #(
    parameter int W = 4
);
    logic         E;
    logic [3:0]   MASK;
    logic [W-1:0] D0;
    logic [W-1:0] D1;
    logic [W-1:0] D2;
    logic [W-1:0] D3;
    logic [1:0]   S;
    logic [1:0]   CH;
    logic [W-1:0] Y;
    logic [1:0]   YCH;
    logic         V;
`ifdef MUX_SCAN_PARITY_EN
    logic         P;

    modport master (
        output E, MASK, D0, D1, D2, D3,
        input  S, CH, Y, YCH, V, P
    );

    modport slave (
        input  E, MASK, D0, D1, D2, D3,
        output S, CH, Y, YCH, V, P
    );
`else
    modport master (
        output E, MASK, D0, D1, D2, D3,
        input  S, CH, Y, YCH, V
    );

    modport slave (
        input  E, MASK, D0, D1, D2, D3,
        output S, CH, Y, YCH, V
    );
`endif
endinterface

// File: rtl/modulo_mux4_1_scan.sv
// rtl/modulo_mux4_1_scan.sv - 4:1 time-multiplexed round-robin scanner
//
// Purpose: walks a 2-bit channel pointer over the enabled channels, dwells
//   DWELL cycles on each, then registers that channel's word onto Y with a
//   one-cycle V strobe. Gathering end of modulo_demux1_4.
//   Optional macro: MUX_SCAN_PARITY_EN adds registered even-parity output P.
// Parameters:
//   W      data width of D0..D3 and Y
//   DWELL  cycles per channel before capture (>= 1)
// Ports:
//   clk_i-style scalar clk   rising-edge clock
//   rst                      asynchronous active-high reset
//   bus (slave modport)      E, MASK, D0..D3 in; S, CH, Y, YCH, V (, P) out

module modulo_mux4_1_scan #(
    parameter int W     = 4,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    modulo_mux4_1_scan_if.slave     bus
);
    localparam int             CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     ch_q;
    logic [W-1:0]   y_q;
    logic [1:0]     ych_q;
    logic           v_q;
`ifdef MUX_SCAN_PARITY_EN
    logic           p_q;
`endif

    logic [1:0]     ch_d;
    logic [1:0]     cand;
    logic           found;
    logic [W-1:0]   d_sel;
    logic           go;

    // Scan is live only with E high and at least one channel enabled.
    assign go = bus.E && (bus.MASK != 4'b0000);

    // Next enabled channel searching ch+1, ch+2, ch+3, then ch itself;
    // the 2-bit add supplies the 3->0 wrap.
    always_comb begin
        ch_d  = ch_q;
        cand  = ch_q;
        found = 1'b0;
        for (int i = 1; i < 5; i++) begin
            cand = ch_q + 2'(i);
            if (!found && bus.MASK[cand]) begin
                ch_d  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        case (ch_q)
            2'd0:    d_sel = bus.D0;
            2'd1:    d_sel = bus.D1;
            2'd2:    d_sel = bus.D2;
            default: d_sel = bus.D3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= 2'd0;
            y_q     <= '0;
            ych_q   <= 2'd0;
            v_q     <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            p_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    v_q   <= 1'b0;
                    if (go) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    // Pause takes priority over a coinciding capture edge;
                    // the channel keeps its place and restarts its dwell.
                    if (!go) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        v_q     <= 1'b0;
                    end else if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        ch_q  <= ch_d;
                        if (bus.MASK[ch_q]) begin
                            y_q   <= d_sel;
                            ych_q <= ch_q;
                            v_q   <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                            p_q   <= ^d_sel;
`endif
                        end else begin
                            // Channel was masked during its dwell: skip it.
                            v_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        v_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Bit order matches the decode in modulo_demux1_4.
    assign bus.S   = {ch_q[0], ch_q[1]};
    assign bus.CH  = ch_q;
    assign bus.Y   = y_q;
    assign bus.YCH = ych_q;
    assign bus.V   = v_q;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.P   = p_q;
`endif

endmodule

// File: tb/tb_modulo_mux4_1_scan.sv
// tb/tb_modulo_mux4_1_scan.sv - self-checking bench for modulo_mux4_1_scan

module tb_modulo_mux4_1_scan;
    localparam int W = 4;

    logic clk;
    logic rst;

    int nvec;
    int nerr;

    modulo_mux4_1_scan_if #(.W(W)) if0 ();
    modulo_mux4_1_scan_if #(.W(W)) if1 ();

    modulo_mux4_1_scan #(.W(W), .DWELL(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    modulo_mux4_1_scan #(.W(W), .DWELL(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: one entry per DUT; age counts RUN cycles spent on
    // the current channel, a capture happens when it reaches the dwell.
    int           dw    [2];
    bit           m_run [2];
    int           m_age [2];
    int           m_ch  [2];
    logic [W-1:0] m_y   [2];
    int           m_ych [2];
    bit           m_v   [2];
    bit           m_p   [2];

    initial begin
        dw[0] = 4;
        dw[1] = 1;
    end

    function automatic void m_reset(int i);
        m_run[i] = 0; m_age[i] = 0; m_ch[i] = 0;
        m_y[i] = '0;  m_ych[i] = 0; m_v[i] = 0; m_p[i] = 0;
    endfunction

    function automatic void m_step(int i, logic e, logic [3:0] mask,
                                   logic [W-1:0] a, logic [W-1:0] b,
                                   logic [W-1:0] c, logic [W-1:0] d);
        logic [W-1:0] dd [4];
        int nx;
        bit got;
        dd[0] = a; dd[1] = b; dd[2] = c; dd[3] = d;
        if (!m_run[i]) begin
            m_v[i] = 0;
            m_age[i] = 0;
            if (e && mask != 0) m_run[i] = 1;
        end else if (!e || mask == 0) begin
            m_run[i] = 0;
            m_age[i] = 0;
            m_v[i] = 0;
        end else begin
            m_age[i]++;
            if (m_age[i] == dw[i]) begin
                m_age[i] = 0;
                if (mask[m_ch[i]]) begin
                    m_y[i]   = dd[m_ch[i]];
                    m_ych[i] = m_ch[i];
                    m_v[i]   = 1;
                    m_p[i]   = ^dd[m_ch[i]];
                end else begin
                    m_v[i] = 0;
                end
                nx = m_ch[i];
                got = 0;
                for (int s = 1; s <= 4; s++) begin
                    if (!got && mask[(m_ch[i] + s) % 4]) begin
                        nx = (m_ch[i] + s) % 4;
                        got = 1;
                    end
                end
                m_ch[i] = nx;
            end else begin
                m_v[i] = 0;
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_step(0, if0.E, if0.MASK, if0.D0, if0.D1, if0.D2, if0.D3);
            m_step(1, if1.E, if1.MASK, if1.D0, if1.D1, if1.D2, if1.D3);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_of(int ch);
        return ((ch & 1) << 1) | ((ch >> 1) & 1);
    endfunction

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        check("d0.S",   int'(if0.S),   sel_of(m_ch[0]));
        check("d0.CH",  int'(if0.CH),  m_ch[0]);
        check("d0.Y",   int'(if0.Y),   int'(m_y[0]));
        check("d0.YCH", int'(if0.YCH), m_ych[0]);
        check("d0.V",   int'(if0.V),   int'(m_v[0]));
        check("d1.S",   int'(if1.S),   sel_of(m_ch[1]));
        check("d1.CH",  int'(if1.CH),  m_ch[1]);
        check("d1.Y",   int'(if1.Y),   int'(m_y[1]));
        check("d1.YCH", int'(if1.YCH), m_ych[1]);
        check("d1.V",   int'(if1.V),   int'(m_v[1]));
`ifdef MUX_SCAN_PARITY_EN
        check("d0.P",   int'(if0.P),   int'(m_p[0]));
        check("d1.P",   int'(if1.P),   int'(m_p[1]));
`endif
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until dut0 shows V, returning the number of cycles taken.
    task automatic wait_v0(input int maxc, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!if0.V && n < maxc);
        if (!if0.V) check("timeout_v", 0, 1);
    endtask

    int n;
    int exp_y   [5] = '{1, 2, 3, 4, 1};
    int exp_ych [5] = '{0, 1, 2, 3, 0};
    int exp_s   [5] = '{2, 1, 3, 0, 2};
    int skip_y  [4] = '{3, 1, 3, 1};
    int skip_ch [4] = '{2, 0, 2, 0};
    logic [W-1:0] d3v [8] = '{4'h5, 4'hA, 4'h0, 4'hF, 4'h3, 4'hC, 4'h7, 4'h9};

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        if0.E = 1'b0; if0.MASK = 4'h0;
        if0.D0 = 4'd1; if0.D1 = 4'd2; if0.D2 = 4'd3; if0.D3 = 4'd4;
        if1.E = 1'b0; if1.MASK = 4'h0;
        if1.D0 = 4'd0; if1.D1 = 4'd0; if1.D2 = 4'd0; if1.D3 = 4'd0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset mid-dwell with the scan running.
        if0.E = 1'b1; if0.MASK = 4'hF;
        for (int i = 0; i < 6; i++) cycle();
        check("pre_rst_Y", int'(if0.Y), 1);
        check("pre_rst_CH", int'(if0.CH), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_S",   int'(if0.S),   0);
        check("rst_CH",  int'(if0.CH),  0);
        check("rst_Y",   int'(if0.Y),   0);
        check("rst_YCH", int'(if0.YCH), 0);
        check("rst_V",   int'(if0.V),   0);
        @(negedge clk);
        if0.E = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("idle_hold", int'({if0.S, if0.CH, if0.Y, if0.YCH, if0.V}), 0);
        end

        // Full scan, all channels enabled.
        if0.E = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_v0(10, n);
            check("scan_gap", n, (k == 0) ? 5 : 4);
            check("scan_Y",   int'(if0.Y),   exp_y[k]);
            check("scan_YCH", int'(if0.YCH), exp_ych[k]);
            check("scan_S",   int'(if0.S),   exp_s[k]);
        end

        // Pause on channel 1 at cnt=2 for 5 cycles.
        cycle();
        cycle();
        if0.E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("pause_V", int'(if0.V), 0);
            check("pause_CH", int'(if0.CH), 1);
        end
        if0.E = 1'b1;
        cycle();
        wait_v0(10, n);
        check("resume_gap", n, 4);
        check("resume_Y", int'(if0.Y), 2);
        check("resume_YCH", int'(if0.YCH), 1);

        // Skip: only channels 0 and 2.
        if0.MASK = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_v0(10, n);
            check("skip_gap", n, 4);
            check("skip_Y",   int'(if0.Y),   skip_y[k]);
            check("skip_YCH", int'(if0.YCH), skip_ch[k]);
        end
        if0.MASK = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("mask0_V", int'(if0.V), 0);
            check("mask0_Y", int'(if0.Y), 1);
            check("mask0_CH", int'(if0.CH), 2);
        end

        // DWELL=1 on channel 3 only.
        if1.MASK = 4'b1000;
        if1.E = 1'b1;
        if1.D3 = d3v[0];
        cycle();
        cycle();
        for (int k = 0; k < 8; k++) begin
            if1.D3 = d3v[k];
            cycle();
            check("dw1_V",  int'(if1.V),  1);
            check("dw1_CH", int'(if1.CH), 3);
            check("dw1_Y",  int'(if1.Y),  int'(d3v[k]));
        end
        if1.E = 1'b0;

`ifdef MUX_SCAN_PARITY_EN
        // Parity: dut0 resumes from channel 2 with all channels enabled.
        if0.D1 = 4'b0111;
        if0.D2 = 4'b0011;
        if0.MASK = 4'hF;
        if0.E = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_v0(10, n);
            if (if0.YCH == 2'd1) check("par_D1", int'(if0.P), 1);
            if (if0.YCH == 2'd2) check("par_D2", int'(if0.P), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
